bus_share_arbiter: RTL and testbench
====================================

# bus_share_arbiter

Two-requester arbiter for the shared 16-bit operand bus of the accumulator datapath. It picks which requester owns the bus and drives the select line of the 2-input, 16-bit bus mux. It registers the selected word onto the bus with a valid strobe. Ownership is held for a multi-beat transaction, and a hold limit bounds starvation.

## Interface
- DATA_W, 16, width of requester data and bus word
- MAX_HOLD, 4, beats an owner may issue before it must yield to a waiting requester (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  requester wants or holds the bus; held high for the whole transaction
- data0 / data1  in  DATA_W  requester word, sampled on a beat
- last0 / last1  in  1  the current beat is the final beat of the transaction
- gnt0 / gnt1  out  1  registered grant; at most one high
- sel  out  1  registered mux select to the bus mux (0 = requester 0, 1 = requester 1)
- bus_data  out  DATA_W  registered bus word
- bus_valid  out  1  bus_data holds a new beat this cycle
- busy  out  1  high in OWN0 or OWN1

## Operation
- States:
  - IDLE: no grant.
  - OWN0: gnt0=1, sel=0.
  - OWN1: gnt1=1, sel=1.
- Round-robin pointer `rr`:
  - Names the preferred requester when both are requesting.
  - Reset value 0.
  - Set to the other index whenever an ownership ends.
- IDLE:
  - Only req0 high → OWN0.
  - Only req1 high → OWN1.
  - Both high → OWN[rr].
  - Neither high → stay in IDLE.
- Beat: a cycle with gntX=1 and reqX=1. On a beat, bus_data ← dataX, bus_valid ← 1, and beat counter `hc` increments (saturates at MAX_HOLD).
- Ownership ends at the end of the current cycle on any of:
  - a beat with lastX=1 (normal end);
  - reqX=0 while granted (abort, no beat issued);
  - a beat that makes hc = MAX_HOLD while the other req is high (preemption).
- Transition at end of ownership: other req high → go directly to OWN(other), with hc cleared and no IDLE bubble. Otherwise → IDLE.
- Hold limit with no contender: hc saturates at MAX_HOLD and the owner keeps the bus.
- Preemption mid-transaction: the preempted requester keeps req high and resumes its transaction when re-granted. The arbiter keeps no per-transaction state.
- Default outputs: bus_valid=0 on any non-beat cycle; bus_data holds its last value.
- Reset (at any time, including mid-transaction) forces:
  - state IDLE, rr=0, hc=0;
  - gnt0=gnt1=0, sel=0, bus_data=0, bus_valid=0, busy=0.

## Timing
- Request to grant: req sampled at edge N from IDLE gives gnt/sel high after edge N. The first beat can occur in cycle N+1.
- Beat to bus: a beat in cycle K gives bus_data/bus_valid after edge K, i.e. 1-cycle latency.
- Handover without a bubble: the last beat of owner A is in cycle K; gntB is high in cycle K+1; B's first beat can be in K+1.
- Grant edges: gnt0/gnt1 never both high. sel changes only on the edge where ownership changes.
- Abort cycle: when reqX drops while granted, that cycle issues no beat and bus_valid=0 on the following cycle.

## Configuration
- `ARB_FIXED_PRIO_EN`, defined:
  - Requester 0 wins every contest; rr is ignored.
  - Preemption applies only to owner 1 when req0 is waiting. Owner 0 is never preempted.
- `ARB_FIXED_PRIO_EN`, undefined: round-robin as above, and the hold limit applies to both owners.

## Test plan
- Single transaction:
  - Stimulus: req0 with 3 beats, data 0x0011, 0x0022, 0x0033; last0 on the 3rd beat.
  - Required: gnt0 one cycle after req0; bus_data carries 0x0011, 0x0022, 0x0033 on 3 consecutive cycles with bus_valid; then IDLE, busy=0.
- Simultaneous requests:
  - Stimulus: req0 and req1 rise together, each a 1-beat transaction (data0=0xAAAA, data1=0x5555).
  - Required: first OWN0, then OWN1 with no idle cycle between; bus_data 0xAAAA then 0x5555. A second simultaneous pair is served 1 first.
- Preemption:
  - Stimulus: MAX_HOLD=4; req0 runs an 8-beat transaction; req1 goes high at beat 2.
  - Required: after owner 0's 4th beat, sel→1 and req1's transaction is served. Owner 0 then resumes with beats 5–8.
- Abort:
  - Stimulus: req1 drops after 2 beats without last1.
  - Required: no bus_valid in the abort cycle; return to IDLE.
- Reset mid-transaction:
  - Stimulus: assert rst during beat 2 of an OWN1 transaction.
  - Required: next cycle all outputs are 0 and state is IDLE. Then, with both req high, OWN0 is granted first (rr=0).
- Fixed priority:
  - Stimulus: build with `ARB_FIXED_PRIO_EN`; hold req0 and req1 high continuously.
  - Required: requester 0 owns the bus indefinitely and gnt1 never rises.

Source files
------------

// File: rtl/bus_share_arbiter.sv
// rtl/bus_share_arbiter.sv - two-requester operand-bus arbiter with multi-beat hold and hold limit
// Optional ARB_FIXED_PRIO_EN: requester 0 wins every contest and only owner 1 can be preempted.
module bus_share_arbiter #(
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              last0,
  input  logic              last1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  output logic              busy
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

`ifdef ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic [HC_W-1:0]   hc_q, hc_d, hc_inc;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              bus_valid_q, bus_valid_d;

  logic              owner;
  logic              own_req;
  logic              own_last;
  logic              other_req;
  logic [DATA_W-1:0] own_data;
  logic              preempt_ok;
  logic              ownership_end;
  logic              idle_pick;

  always_comb begin
    owner      = (state_q == S_OWN1);
    own_req    = owner ? req1  : req0;
    own_last   = owner ? last1 : last0;
    own_data   = owner ? data1 : data0;
    other_req  = owner ? req0  : req1;
    hc_inc     = (hc_q == HC_MAX) ? hc_q : hc_q + HC_W'(1);
    preempt_ok = !FIXED_PRIO || owner;
    idle_pick  = FIXED_PRIO ? 1'b0 : rr_q;

    state_d       = state_q;
    rr_d          = rr_q;
    hc_d          = hc_q;
    bus_data_d    = bus_data_q;
    bus_valid_d   = 1'b0;
    ownership_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        hc_d = '0;
        if (req0 && req1) begin
          state_d = idle_pick ? S_OWN1 : S_OWN0;
        end else if (req0) begin
          state_d = S_OWN0;
        end else if (req1) begin
          state_d = S_OWN1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (!own_req) begin
          ownership_end = 1'b1;
        end else begin
          bus_valid_d   = 1'b1;
          bus_data_d    = own_data;
          hc_d          = hc_inc;
          // A saturated count still preempts once a contender shows up.
          ownership_end = own_last || ((hc_inc == HC_MAX) && other_req && preempt_ok);
        end
        if (ownership_end) begin
          rr_d    = ~owner;
          hc_d    = '0;
          state_d = other_req ? (owner ? S_OWN0 : S_OWN1) : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        hc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      hc_q        <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      hc_q        <= hc_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign gnt0      = (state_q == S_OWN0);
  assign gnt1      = (state_q == S_OWN1);
  assign sel       = (state_q == S_OWN1);
  assign busy      = (state_q == S_OWN0) || (state_q == S_OWN1);
  assign bus_data  = bus_data_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// tb/tb_bus_share_arbiter.sv - randomized and directed bench for bus_share_arbiter against a cycle model
module tb_bus_share_arbiter;

  localparam int DATA_W   = 16;
  localparam int MAX_HOLD = 4;
  localparam int QD       = 256;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, last0, last1;
  logic [DATA_W-1:0] data0, data1;
  logic              gnt0, gnt1, sel, bus_valid, busy;
  logic [DATA_W-1:0] bus_data;

  bus_share_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .bus_data(bus_data), .bus_valid(bus_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  string cur_test = "init";

  // Reference model: owner index (-1 = nobody), preferred requester, beats held.
  int          m_own, m_rr, m_hc;
  logic [15:0] m_bd;
  bit          m_bv;

  // Requester agents: per-requester transaction lists.
  int t_len[2][QD], t_abort[2][QD], t_gap[2][QD], t_base[2][QD];
  int hd[2], tl[2], done_b[2], gap_left[2];
  bit started[2];

  logic [15:0] obs[$];
  int          obs_cyc[$];

  task automatic clear_agents();
    for (int i = 0; i < 2; i++) begin
      hd[i] = 0; tl[i] = 0; done_b[i] = 0; gap_left[i] = 0; started[i] = 0;
    end
    obs.delete();
    obs_cyc.delete();
  endtask

  task automatic push(input int i, input int len, input int abort_at, input int gap, input int base);
    t_len[i][tl[i]] = len; t_abort[i][tl[i]] = abort_at;
    t_gap[i][tl[i]] = gap; t_base[i][tl[i]] = base;
    tl[i]++;
  endtask

  task automatic step(input bit do_rst);
    logic        r[2];
    logic        l[2];
    logic [15:0] d[2];
    bit          ab[2];
    bit          beat[2];
    int          n_own, n_rr, n_hc, me, other;
    logic [15:0] n_bd;
    bit          n_bv, fin;
    logic [20:0] exp_v, act_v;
    for (int i = 0; i < 2; i++) begin
      r[i] = 1'b0; l[i] = 1'b0; d[i] = 16'($urandom); ab[i] = 1'b0;
      if (hd[i] < tl[i]) begin
        if (!started[i]) begin
          gap_left[i] = t_gap[i][hd[i]];
          started[i]  = 1'b1;
        end
        if (gap_left[i] == 0) begin
          if (t_abort[i][hd[i]] > 0 && done_b[i] == t_abort[i][hd[i]]) begin
            ab[i] = 1'b1;
          end else begin
            r[i] = 1'b1;
            d[i] = 16'(t_base[i][hd[i]] * (done_b[i] + 1));
            l[i] = (done_b[i] == t_len[i][hd[i]] - 1);
          end
        end
      end
    end
    rst = do_rst;
    req0 = r[0]; data0 = d[0]; last0 = l[0];
    req1 = r[1]; data1 = d[1]; last1 = l[1];

    for (int i = 0; i < 2; i++) beat[i] = !do_rst && (m_own == i) && r[i];

    if (do_rst) begin
      m_own = -1; m_rr = 0; m_hc = 0; m_bd = 16'h0; m_bv = 1'b0;
    end else begin
      n_own = m_own; n_rr = m_rr; n_hc = m_hc; n_bd = m_bd; n_bv = 1'b0;
      if (m_own < 0) begin
        if (r[0] && r[1]) n_own = FIXED ? 0 : m_rr;
        else if (r[0]) n_own = 0;
        else if (r[1]) n_own = 1;
        n_hc = 0;
      end else begin
        me = m_own; other = 1 - me; fin = 1'b0;
        if (!r[me]) begin
          fin = 1'b1;
        end else begin
          n_bd = d[me]; n_bv = 1'b1;
          n_hc = (m_hc < MAX_HOLD) ? m_hc + 1 : MAX_HOLD;
          fin  = l[me] || (n_hc == MAX_HOLD && r[other] && (!FIXED || me == 1));
        end
        if (fin) begin
          n_rr = other; n_hc = 0;
          n_own = r[other] ? other : -1;
        end
      end
      m_own = n_own; m_rr = n_rr; m_hc = n_hc; m_bd = n_bd; m_bv = n_bv;
    end

    for (int i = 0; i < 2; i++) begin
      if (hd[i] < tl[i] && started[i]) begin
        if (gap_left[i] > 0) begin
          gap_left[i]--;
        end else if (ab[i]) begin
          hd[i]++; done_b[i] = 0; started[i] = 1'b0;
        end else if (beat[i]) begin
          done_b[i]++;
          if (done_b[i] == t_len[i][hd[i] - 0]) begin
            hd[i]++; done_b[i] = 0; started[i] = 1'b0;
          end
        end
      end
    end

    @(negedge clk);
    cyc++;
    exp_v = {(m_own == 0), (m_own == 1), (m_own == 1), (m_own >= 0), m_bv, m_bd};
    act_v = {gnt0, gnt1, sel, busy, bus_valid, bus_data};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d {gnt0,gnt1,sel,busy,valid,data}: got %h expected %h",
               cur_test, cyc, act_v, exp_v);
    end
    if (bus_valid === 1'b1) begin
      obs.push_back(bus_data);
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    clear_agents();
    step(1'b1);
    step(1'b1);
    obs.delete();
    obs_cyc.delete();
  endtask

  task automatic run_idle(input int max_cyc);
    int  n = 0;
    bit  settled = 1'b0;
    while (!settled && n < max_cyc) begin
      step(1'b0);
      n++;
      settled = (hd[0] == tl[0]) && (hd[1] == tl[1]) && (m_own < 0);
    end
    n_cmp++;
    if (!settled) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d cycles without settling, required settle within %0d", cur_test, n, max_cyc);
    end
  endtask

  task automatic check_log(input string name, input logic [15:0] exp_q[$]);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s beat count: got %0d required %0d", name, obs.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL %s beat %0d: got %h required %h", name, k, obs[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    n_cmp++;
    if ({gnt0, gnt1, sel, busy, bus_valid, bus_data} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {gnt0, gnt1, sel, busy, bus_valid, bus_data});
    end
    step(1'b0);
  endtask

  task automatic test_single();
    cur_test = "single";
    do_reset();
    push(0, 3, 0, 0, 'h0011);
    run_idle(30);
    check_log("single_data", '{16'h0011, 16'h0022, 16'h0033});
  endtask

  task automatic test_simultaneous();
    cur_test = "simultaneous";
    do_reset();
    push(0, 1, 0, 0, 'hAAAA);
    push(1, 1, 0, 0, 'h5555);
    run_idle(30);
    check_log("simul_first_pair", '{16'hAAAA, 16'h5555});
    n_cmp++;
    if (obs_cyc.size() != 2 || obs_cyc[1] - obs_cyc[0] != 1) begin
      n_fail++;
      $display("FAIL simul_no_bubble: got %0d beats non-adjacent, required 2 adjacent", obs_cyc.size());
    end
    obs.delete();
    push(0, 1, 0, 0, 'h0101);
    run_idle(30);
    push(0, 1, 0, 0, 'hAAAA);
    push(1, 1, 0, 0, 'h5555);
    run_idle(30);
    if (FIXED) check_log("simul_second_pair", '{16'h0101, 16'hAAAA, 16'h5555});
    else       check_log("simul_second_pair", '{16'h0101, 16'h5555, 16'hAAAA});
  endtask

  task automatic test_preempt();
    cur_test = "preempt";
    do_reset();
    push(0, 8, 0, 0, 'h0100);
    push(1, 2, 0, 2, 'h0B00);
    run_idle(40);
    if (FIXED)
      check_log("preempt_order", '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                                   16'h0600, 16'h0700, 16'h0800, 16'h0B00, 16'h1600});
    else
      check_log("preempt_order", '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0B00,
                                   16'h1600, 16'h0500, 16'h0600, 16'h0700, 16'h0800});
    n_cmp++;
    if (obs_cyc.size() != 10 || obs_cyc[9] - obs_cyc[0] != 9) begin
      n_fail++;
      $display("FAIL preempt_no_bubble: got %0d beats, required 10 back-to-back", obs_cyc.size());
    end
  endtask

  task automatic test_abort();
    cur_test = "abort";
    do_reset();
    push(1, 5, 2, 0, 'h0030);
    run_idle(30);
    check_log("abort_data", '{16'h0030, 16'h0060});
  endtask

  task automatic test_reset_mid();
    cur_test = "reset_mid";
    do_reset();
    push(1, 4, 0, 0, 'h0007);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    n_cmp++;
    if ({gnt0, gnt1, sel, busy, bus_valid, bus_data} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h required 0", {gnt0, gnt1, sel, busy, bus_valid, bus_data});
    end
    clear_agents();
    push(0, 1, 0, 0, 'h0A0A);
    push(1, 1, 0, 0, 'h0B0B);
    run_idle(30);
    check_log("reset_mid_rr", '{16'h0A0A, 16'h0B0B});
  endtask

  task automatic test_fixed_prio();
    int dut_g1 = 0;
    int mdl_g1 = 0;
    cur_test = "fixed_prio";
    do_reset();
    push(0, 1000, 0, 0, 'h0001);
    push(1, 3, 0, 0, 'h0002);
    for (int k = 0; k < 40; k++) begin
      step(1'b0);
      if (gnt1 === 1'b1) dut_g1++;
      if (m_own == 1) mdl_g1++;
    end
    n_cmp++;
    if (dut_g1 != mdl_g1) begin
      n_fail++;
      $display("FAIL fixed_prio_gnt1_cycles: got %0d required %0d", dut_g1, mdl_g1);
    end
    do_reset();
  endtask

  task automatic test_random();
    cur_test = "random";
    do_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 80; k++) begin
        int len;
        len = int'($urandom_range(1, 7));
        push(i, len, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0,
             int'($urandom_range(0, 3)), int'($urandom_range(1, 16'hFFFF)));
      end
    end
    run_idle(6000);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    data0 = '0; data1 = '0;
    m_own = -1; m_rr = 0; m_hc = 0; m_bd = 16'h0; m_bv = 1'b0;
    clear_agents();
    @(negedge clk);
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_abort();
    test_reset_mid();
    test_fixed_prio();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
